des_round_ctrl: RTL
===================

# des_round_ctrl

Sequencing controller for the iterative single-round DES core `des_o`. It accepts one encrypt/decrypt job at a time over a valid/ready handshake, holds the block, 56-bit key and direction stable for the core, and drives `roundSel` 0..15 on consecutive cycles. It captures the final-round output and presents it on a valid/ready result port. It also emits one write per round to the 64-bit × 32-word round-log RAM (`ram1`), replacing the free-running round counter in the `des` top level.

## Interface
- `ROUNDS`, 16: rounds per job; must equal the core's round count.
- `LOG_AW`, 5: log RAM address width; one address bit above the round index selects the log half.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `in_valid`  in  1  job offered.
- `in_ready`  out  1  controller can accept a job.
- `in_block`  in  64  plaintext or ciphertext.
- `in_key`  in  56  parity-stripped key.
- `in_decrypt`  in  1  1 = decrypt.
- `abort`  in  1  synchronous cancel of the current job.
- `core_des_in`  out  64  to core `desIn`.
- `core_key`  out  56  to core `key`.
- `core_decrypt`  out  1  to core `decrypt`.
- `core_round_sel`  out  4  to core `roundSel`.
- `core_des_out`  in  64  from core `desOut`.
- `out_valid`  out  1  result available.
- `out_ready`  in  1  consumer takes the result.
- `out_block`  out  64  result.
- `log_wren`  out  1  round-log write strobe.
- `log_addr`  out  `LOG_AW`  round-log address.
- `log_data`  out  64  round-log data (`core_des_out`).
- `busy`  out  1  state is not IDLE.

## Operation
- States: IDLE, RUN, DONE.
- **IDLE**
  - `in_ready = !abort`.
  - On `in_valid && in_ready`: register `in_block`, `in_key` and `in_decrypt` into the `core_*` registers, clear the round counter, go to RUN.
- **RUN**
  - `core_round_sel` = round counter; the counter increments once per cycle.
  - Each cycle: `log_wren = 1`, `log_addr = {half, round}`, `log_data = core_des_out`.
  - On the cycle where round = `ROUNDS-1`: load `out_block` from `core_des_out`, toggle `half`, go to DONE.
- **DONE**
  - `out_valid = 1`; `out_block` stays stable.
  - On `out_valid && out_ready`: go to IDLE.
- **abort** (any state): go to IDLE next edge. No result is produced, the log write in that cycle is suppressed, and `half` does not toggle. If `abort` and `in_valid` are high together in IDLE, the job is not accepted.
- `core_round_sel` is 0 outside RUN. The `core_*` data registers hold their last value outside RUN.
- Round counter is 4 bits, reset and cleared to 0, and never wraps inside a job.
- `half` starts at 0 and alternates per completed job, so consecutive jobs log to words 0–15 and 16–31.
- Reset (any time, including mid-RUN): state IDLE, counter 0, `half` 0, and these outputs 0:
  - `core_des_in`, `core_key`, `core_decrypt`, `out_block`, `out_valid`
  - `log_wren`, `busy`
  - `in_ready` while `rst` is high.

## Timing
- Accept at edge T.
- RUN occupies cycles T..T+15 (edges T+1..T+16), with `core_round_sel` 0..15.
- `out_valid` rises after edge T+16. Latency from accept to `out_valid` is 16 cycles.
- Minimum job period is 18 cycles: 16 RUN, 1 DONE with `out_ready` high, 1 IDLE accept.
- `in_ready` is combinational from state and `abort`; `out_valid` is registered.
- `log_*` are valid in the same cycle as the corresponding `core_round_sel`, so the RAM write samples the matching round output.
- `out_valid` stays high with `out_block` unchanged under any number of `out_ready`-low cycles.

## Structure
- Shared package `des_pkg`:
  - state encoding (`DES_IDLE`, `DES_RUN`, `DES_DONE`)
  - `DES_ROUNDS = 16`
  - `DES_KEY_W = 56`, `DES_BLK_W = 64`
  - key-compaction function mapping a 64-bit key to `key56`
- Sub-module: none. One FSM plus a counter. The existing `des` top instantiates `des_round_ctrl`, `des_o` and `ram1`.

## Test plan
- **Known-answer encrypt:** key 64'h133457799BBCDFF1 (compacted), block 64'h0123456789ABCDEF, decrypt 0 → `out_block` 64'h85E813540F0AB405; `out_valid` 16 cycles after accept.
- **Known-answer decrypt:** same key, block 64'h85E813540F0AB405, decrypt 1 → 64'h0123456789ABCDEF.
- **Log check, two back-to-back jobs:** 16 writes to addresses 0–15, then 16 writes to 16–31. Word 15 equals the first job's `out_block`.
- **Backpressure:** `out_ready` low for 10 cycles after `out_valid` → `out_block` stable, `in_ready` 0, `busy` 1; accept happens in the cycle after the `out_ready` handshake.
- **Abort at round 7:**
  - Next cycle: IDLE, `out_valid` never asserted, no write at round 7.
  - A following job logs into the same half and produces the correct result.
- **Async reset mid-RUN (round 9):** all outputs 0 immediately. After release, `in_ready` 1, and a new job starts at round 0 and logs at address 0.

Source files
------------

// File: rtl/des_pkg.sv
// Shared DES definitions: controller states, widths and key compaction.
package des_pkg;

  localparam int unsigned DES_ROUNDS = 16;
  localparam int unsigned DES_KEY_W  = 56;
  localparam int unsigned DES_BLK_W  = 64;
  localparam int unsigned DES_RND_W  = $clog2(DES_ROUNDS);

  typedef enum logic [1:0] {
    DES_IDLE = 2'b00,
    DES_RUN  = 2'b01,
    DES_DONE = 2'b10
  } des_state_e;

  // Drop the odd-parity bit (LSB of each byte) to get the 56-bit core key.
  function automatic logic [DES_KEY_W-1:0] des_key_compact(input logic [63:0] key64);
    logic [DES_KEY_W-1:0] k;
    k = '0;
    for (int i = 0; i < 8; i++) begin
      k[DES_KEY_W-1-7*i -: 7] = key64[63-8*i -: 7];
    end
    return k;
  endfunction

endpackage

// File: rtl/des_round_ctrl_if.sv
// Job, core, result and round-log signals of the DES round controller.
// slave is the controller's view; master is the surrounding datapath / test view.
interface des_round_ctrl_if
  import des_pkg::*;
#(
  parameter int unsigned LOG_AW = DES_RND_W + 1
) ();

  // Job input
  logic                 in_valid;
  logic                 in_ready;
  logic [DES_BLK_W-1:0] in_block;
  logic [DES_KEY_W-1:0] in_key;
  logic                 in_decrypt;
  logic                 abort;

  // Core side
  logic [DES_BLK_W-1:0] core_des_in;
  logic [DES_KEY_W-1:0] core_key;
  logic                 core_decrypt;
  logic [DES_RND_W-1:0] core_round_sel;
  logic [DES_BLK_W-1:0] core_des_out;

  // Result
  logic                 out_valid;
  logic                 out_ready;
  logic [DES_BLK_W-1:0] out_block;

  // Round log RAM write port
  logic                 log_wren;
  logic [LOG_AW-1:0]    log_addr;
  logic [DES_BLK_W-1:0] log_data;

  logic                 busy;

  modport slave (
    input  in_valid, in_block, in_key, in_decrypt, abort, core_des_out, out_ready,
    output in_ready, core_des_in, core_key, core_decrypt, core_round_sel,
           out_valid, out_block, log_wren, log_addr, log_data, busy
  );

  modport master (
    output in_valid, in_block, in_key, in_decrypt, abort, core_des_out, out_ready,
    input  in_ready, core_des_in, core_key, core_decrypt, core_round_sel,
           out_valid, out_block, log_wren, log_addr, log_data, busy
  );

endinterface

// File: rtl/des_round_ctrl.sv
// Sequencing controller for the iterative single-round DES core. Accepts one job,
// holds block/key/direction for the core, walks roundSel 0..ROUNDS-1, logs every
// round output to the round-log RAM and presents the final output as a result.
module des_round_ctrl
  import des_pkg::*;
#(
  parameter int unsigned ROUNDS = DES_ROUNDS,
  parameter int unsigned LOG_AW = DES_RND_W + 1
) (
  input logic            clk,
  input logic            rst,
  des_round_ctrl_if.slave bus
);

  localparam int unsigned   RW         = DES_RND_W;
  localparam logic [RW-1:0] LAST_ROUND = RW'(ROUNDS - 1);

  des_state_e           state_q, state_d;
  logic [RW-1:0]        round_q, round_d;
  logic                 half_q, half_d;
  logic [DES_BLK_W-1:0] des_in_q, des_in_d;
  logic [DES_KEY_W-1:0] key_q, key_d;
  logic                 decrypt_q, decrypt_d;
  logic [DES_BLK_W-1:0] out_block_q, out_block_d;

  // State, counter, log half and held job/result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= DES_IDLE;
      round_q     <= '0;
      half_q      <= 1'b0;
      des_in_q    <= '0;
      key_q       <= '0;
      decrypt_q   <= 1'b0;
      out_block_q <= '0;
    end else begin
      state_q     <= state_d;
      round_q     <= round_d;
      half_q      <= half_d;
      des_in_q    <= des_in_d;
      key_q       <= key_d;
      decrypt_q   <= decrypt_d;
      out_block_q <= out_block_d;
    end
  end

  // Next-state: accept in IDLE, count rounds in RUN, hold the result in DONE.
  // abort wins everywhere and never toggles half or loads a result.
  always_comb begin
    state_d     = state_q;
    round_d     = round_q;
    half_d      = half_q;
    des_in_d    = des_in_q;
    key_d       = key_q;
    decrypt_d   = decrypt_q;
    out_block_d = out_block_q;

    case (state_q)
      DES_IDLE: begin
        if (bus.in_valid && !bus.abort) begin
          des_in_d  = bus.in_block;
          key_d     = bus.in_key;
          decrypt_d = bus.in_decrypt;
          round_d   = '0;
          state_d   = DES_RUN;
        end
      end
      DES_RUN: begin
        if (bus.abort) begin
          round_d = '0;
          state_d = DES_IDLE;
        end else if (round_q == LAST_ROUND) begin
          out_block_d = bus.core_des_out;
          half_d      = ~half_q;
          round_d     = '0;
          state_d     = DES_DONE;
        end else begin
          round_d = round_q + 1'b1;
        end
      end
      DES_DONE: begin
        if (bus.abort || bus.out_ready) begin
          state_d = DES_IDLE;
        end
      end
      default: begin
        round_d = '0;
        state_d = DES_IDLE;
      end
    endcase
  end

  // in_ready is forced low while reset is held so nothing is offered a handshake.
  assign bus.in_ready       = (state_q == DES_IDLE) && !bus.abort && !rst;
  assign bus.busy           = (state_q != DES_IDLE);
  assign bus.out_valid      = (state_q == DES_DONE);
  assign bus.out_block      = out_block_q;

  assign bus.core_des_in    = des_in_q;
  assign bus.core_key       = key_q;
  assign bus.core_decrypt   = decrypt_q;
  assign bus.core_round_sel = (state_q == DES_RUN) ? round_q : '0;

  // Log write aligns with core_round_sel so the RAM captures that round's output.
  assign bus.log_wren       = (state_q == DES_RUN) && !bus.abort;
  assign bus.log_addr       = LOG_AW'({half_q, round_q});
  assign bus.log_data       = bus.core_des_out;

endmodule
